// File: rtl/uart_regif_if.sv
// uart_regif_if: valid/ready load/store bus between a softcore processor (master)
// and the uart_regif register front end (slave).
interface uart_regif_if;
    logic        bus_valid;
    logic        bus_write;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_write, bus_addr, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_write, bus_addr, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/uart_regif.sv
// uart_regif: memory-mapped register front end for the UART core with TX/RX byte FIFOs.
// Define UART_REGIF_IRQ_EN to implement the CTRL register and the level interrupt.
module uart_regif #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    uart_regif_if.slave bus,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic        irq
);
    localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_RESP} state_e;
    typedef enum logic [1:0] {A_TXDATA = 2'd0, A_RXDATA = 2'd1, A_STATUS = 2'd2, A_CTRL = 2'd3} reg_e;

    state_e            state_q, state_d;
    logic              accept;
    reg_e              sel;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       status;
    logic [31:0]       ctrl_rd;

    logic [7:0]        tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wr_q, tx_rd_q;
    logic [LVL_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic              tx_full, tx_empty, tx_push, tx_pop, tx_ovf_q, ovf_set, ovf_clr;

    logic [7:0]        rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rx_wr_q, rx_rd_q;
    logic [LVL_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              rx_full, rx_empty, rx_push, rx_pop;

    logic [31:0]       tx_lvl, rx_lvl;
    logic              unused_bits;

    assign sel = reg_e'(bus.bus_addr[3:2]);

    // Request accepted only while no response is pending: one transaction per 2 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.bus_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
        endcase
    end

    assign bus.bus_ready = (state_q == ST_RESP);
    assign bus.bus_rdata = rdata_q;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_push = accept && bus.bus_write && (sel == A_TXDATA) && !tx_full;
    assign ovf_set = accept && bus.bus_write && (sel == A_TXDATA) && tx_full;
    assign ovf_clr = accept && bus.bus_write && (sel == A_STATUS) && bus.bus_wdata[4];
    assign tx_pop  = !tx_empty && uart_tx_ready;
    assign rx_push = uart_rx_valid && !rx_full;
    assign rx_pop  = accept && !bus.bus_write && (sel == A_RXDATA) && !rx_empty;

    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_empty ? '0 : tx_mem[tx_rd_q];
    assign uart_rx_ready = !rx_full;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)
            tx_cnt_d = tx_cnt_q + LVL_W'(1);
        else if (!tx_push && tx_pop)
            tx_cnt_d = tx_cnt_q - LVL_W'(1);
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)
            rx_cnt_d = rx_cnt_q + LVL_W'(1);
        else if (!rx_push && rx_pop)
            rx_cnt_d = rx_cnt_q - LVL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + PTR_W'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_W'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + PTR_W'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + PTR_W'(1);
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (ovf_set)
                tx_ovf_q <= 1'b1;
            else if (ovf_clr)
                tx_ovf_q <= 1'b0;
        end
    end

    // Storage needs no reset: the counts gate every read of it.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= bus.bus_wdata[7:0];
        if (rx_push) rx_mem[rx_wr_q] <= uart_rx_data;
    end

    assign tx_lvl = 32'(tx_cnt_q);
    assign rx_lvl = 32'(rx_cnt_q);
    assign status = {8'b0, rx_lvl[7:0], tx_lvl[7:0], 3'b0, tx_ovf_q,
                     rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rdata_d = '0;
        if (accept && !bus.bus_write) begin
            case (sel)
                A_TXDATA: rdata_d = '0;
                A_RXDATA: rdata_d = rx_empty ? '0 : {23'b0, 1'b1, rx_mem[rx_rd_q]};
                A_STATUS: rdata_d = status;
                A_CTRL:   rdata_d = ctrl_rd;
            endcase
        end
    end

`ifdef UART_REGIF_IRQ_EN
    logic rx_irq_en_q, tx_irq_en_q, irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (accept && bus.bus_write && (sel == A_CTRL)) begin
                rx_irq_en_q <= bus.bus_wdata[0];
                tx_irq_en_q <= bus.bus_wdata[1];
            end
            irq_q <= (rx_irq_en_q && !rx_empty) || (tx_irq_en_q && tx_empty);
        end
    end

    assign ctrl_rd = {30'b0, tx_irq_en_q, rx_irq_en_q};
    assign irq     = irq_q;
`else
    assign ctrl_rd = '0;
    assign irq     = 1'b0;
`endif

    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:8], tx_lvl[31:8], rx_lvl[31:8]};
endmodule

// File: tb/tb_uart_regif.sv
// tb_uart_regif: randomized and directed stimulus against a queue-based reference model;
// bus responses are checked by a scoreboard monitor decoupled from the driver.
module tb_uart_regif;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready = 1'b0;
    logic [7:0] uart_rx_data  = 8'h00;
    logic       uart_rx_valid = 1'b0;
    logic       uart_rx_ready;
    logic       irq;

    uart_regif_if bus();

    uart_regif #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  m_tx[$];
    logic [7:0]  m_rx[$];
    bit          m_ovf, m_rxen, m_txen, m_irq, m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the oldest expected read value whenever the DUT acknowledges.
    always @(negedge clk) begin
        if (!rst && bus.bus_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL bus_ready: response with no request outstanding (t=%0t)", $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                n_cmp--;
                chk("bus_rdata", bus.bus_rdata, e);
            end
        end else if (!rst) begin
            chk("bus_rdata_idle", bus.bus_rdata, 32'h0);
        end
    end

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (m_tx.size() == DEPTH);
        s[1]     = (m_tx.size() == 0);
        s[2]     = (m_rx.size() == DEPTH);
        s[3]     = (m_rx.size() == 0);
        s[4]     = m_ovf;
        s[15:8]  = 8'(m_tx.size());
        s[23:16] = 8'(m_rx.size());
        return s;
    endfunction

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_rxen = 1'b0;
        m_txen = 1'b0;
        m_irq  = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_bus_ready", 32'(bus.bus_ready), 32'h0);
        chk("rst_bus_rdata", bus.bus_rdata, 32'h0);
        chk("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("rst_tx_data", 32'(uart_tx_data), 32'h0);
        chk("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);
    endtask

    // One clock: check outputs against the model, apply this edge's effects, advance.
    task automatic step(input bit rst_mid = 1'b0);
        bit          acc, wr, tx_full, tx_pop, rx_pop, rx_push, irq_n;
        int          sel;
        logic [31:0] rd;
        #1;
        chk("bus_ready", 32'(bus.bus_ready), 32'(m_pend));
        chk("tx_valid", 32'(uart_tx_valid), 32'(m_tx.size() != 0));
        chk("tx_data", 32'(uart_tx_data), (m_tx.size() != 0) ? 32'(m_tx[0]) : 32'h0);
        chk("rx_ready", 32'(uart_rx_ready), 32'(m_rx.size() < DEPTH));
        chk("irq", 32'(irq), 32'(m_irq));

        acc     = bus.bus_valid && !m_pend;
        wr      = bus.bus_write;
        sel     = int'(bus.bus_addr[3:2]);
        tx_full = (m_tx.size() == DEPTH);
        rd      = '0;
        if (acc && !wr) begin
            case (sel)
                1: if (m_rx.size() > 0) rd = 32'h100 | 32'(m_rx[0]);
                2: rd = m_status();
`ifdef UART_REGIF_IRQ_EN
                3: rd = {30'b0, m_txen, m_rxen};
`endif
                default: rd = '0;
            endcase
        end
        if (acc) exp_q.push_back(rd);
        tx_pop  = (m_tx.size() > 0) && uart_tx_ready;
        rx_pop  = acc && !wr && sel == 1 && m_rx.size() > 0;
        rx_push = uart_rx_valid && m_rx.size() < DEPTH;
`ifdef UART_REGIF_IRQ_EN
        irq_n   = (m_rxen && m_rx.size() > 0) || (m_txen && m_tx.size() == 0);
`else
        irq_n   = 1'b0;
`endif
        if (tx_pop) void'(m_tx.pop_front());
        if (acc && wr && sel == 0) begin
            if (tx_full) m_ovf = 1'b1;
            else         m_tx.push_back(bus.bus_wdata[7:0]);
        end
        if (acc && wr && sel == 2 && bus.bus_wdata[4]) m_ovf = 1'b0;
`ifdef UART_REGIF_IRQ_EN
        if (acc && wr && sel == 3) begin
            m_rxen = bus.bus_wdata[0];
            m_txen = bus.bus_wdata[1];
        end
`endif
        if (rx_pop)  void'(m_rx.pop_front());
        if (rx_push) m_rx.push_back(uart_rx_data);
        m_irq  = irq_n;
        m_pend = acc;

        @(posedge clk);
        if (rst_mid) begin
            #2 rst = 1'b1;
            #1 chk_reset_outputs();
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Request cycle (optionally with a receiver byte on the same edge) followed by an idle cycle.
    task automatic bus_req_rx(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                              input bit rxv, input logic [7:0] rxd);
        bus.bus_valid = 1'b1;
        bus.bus_write = wr;
        bus.bus_addr  = addr;
        bus.bus_wdata = wd;
        uart_rx_valid = rxv;
        uart_rx_data  = rxd;
        step();
        bus.bus_valid = 1'b0;
        bus.bus_write = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        uart_rx_valid = 1'b0;
        step();
    endtask

    task automatic bus_req(input bit wr, input logic [3:0] addr, input logic [31:0] wd);
        bus_req_rx(wr, addr, wd, 1'b0, 8'h00);
    endtask

    task automatic rx_inject(input logic [7:0] d);
        uart_rx_valid = 1'b1;
        uart_rx_data  = d;
        step();
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.bus_valid = 1'b0;
        bus.bus_write = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        model_reset();
        #1 rst = 1'b1;
        #1 chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        bus_req(1'b0, 4'h8, 32'h0);

        // TX fill with transmitter stalled, overflow, drain, overflow clear
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) bus_req(1'b1, 4'h0, 32'h41 + 32'(i));
        bus_req(1'b0, 4'h8, 32'h0);
        uart_tx_ready = 1'b1;
        idle(12);
        bus_req(1'b0, 4'h8, 32'h0);
        bus_req(1'b1, 4'h8, 32'h10);
        bus_req(1'b0, 4'h8, 32'h0);
        bus_req(1'b0, 4'h0, 32'h0);

        // RX fill to full, then over-read
        for (int i = 0; i < 8; i++) rx_inject(8'(i));
        rx_inject(8'hEE);
        idle(1);
        bus_req(1'b0, 4'h8, 32'h0);
        for (int i = 0; i < 9; i++) bus_req(1'b0, 4'h4, 32'h0);
        bus_req(1'b1, 4'h4, 32'hFF);

        // Same-edge push and pop at count 3 across the pointer wrap
        for (int i = 0; i < 3; i++) rx_inject(8'h20 + 8'(i));
        for (int i = 0; i < 7; i++) begin
            bus_req_rx(1'b0, 4'h4, 32'h0, 1'b1, 8'h30 + 8'(i));
            bus_req(1'b0, 4'h8, 32'h0);
        end
        for (int i = 0; i < 3; i++) bus_req(1'b0, 4'h4, 32'h0);

        // Interrupt / CTRL
        bus_req(1'b1, 4'hC, 32'h1);
        bus_req(1'b0, 4'hC, 32'h0);
        rx_inject(8'h5A);
        idle(2);
        bus_req(1'b0, 4'h4, 32'h0);
        idle(2);
        bus_req(1'b1, 4'hC, 32'h2);
        idle(2);
        bus_req(1'b0, 4'hC, 32'h0);
        bus_req(1'b1, 4'hC, 32'h0);

        // Reset while a response is pending with 3 TX bytes queued
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_req(1'b1, 4'h0, 32'h60 + 32'(i));
        bus.bus_valid = 1'b1;
        bus.bus_write = 1'b0;
        bus.bus_addr  = 4'h8;
        step(1'b1);
        bus.bus_valid = 1'b0;
        bus.bus_addr  = '0;
        @(posedge clk);
        #1 chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        bus_req(1'b0, 4'h8, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            uart_tx_ready = ($urandom_range(0, 3) == 0);
            uart_rx_valid = ($urandom_range(0, 2) == 0);
            uart_rx_data  = 8'($urandom);
            bus.bus_valid = ($urandom_range(0, 1) == 1);
            bus.bus_write = ($urandom_range(0, 1) == 1);
            bus.bus_addr  = 4'($urandom);
            bus.bus_wdata = $urandom;
            step();
        end
        bus.bus_valid = 1'b0;
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b1;
        idle(12);
        for (int i = 0; i < 10; i++) bus_req(1'b0, 4'h4, 32'h0);
        bus_req(1'b0, 4'h8, 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
